// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path.
// Glyphs are active-low, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble-to-glyph decoder.
// Ports:
//   bcd - 4-bit nibble; 0-9 decode to digits, 10-15 decode to a dash
//   seg - active-low segments {g,f,e,d,c,b,a}
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_display_scan.sv
// Four-digit multiplexed seven-segment driver for the frequency meter.
// A hold register captures Frequency on Update; a prescaler advances the
// digit index every DIV = CLK_FREQ_HZ/SCAN_HZ cycles; An/Seg/Dp are registered.
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero digits
// (digit 0 is never blanked; nibbles 10-15 count as non-zero).
// Ports:
//   Clk       - system clock, rising edge
//   Reset     - asynchronous, active-high
//   Frequency - four packed BCD digits, [15:12] most significant
//   Update    - one-cycle strobe latching Frequency
//   Seg       - active-low segments {g,f,e,d,c,b,a}
//   An        - active-low digit enables, An[0] least significant
//   Dp        - active-low decimal point, always off
module seg_display_scan
  import seg_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100000000,
  parameter int unsigned SCAN_HZ     = 1000
)
(
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [15:0]           Frequency,
  input  logic                  Update,
  output logic [6:0]            Seg,
  output logic [NUM_DIGITS-1:0] An,
  output logic                  Dp
);

  localparam int unsigned DIV   = CLK_FREQ_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  generate
    if ((CLK_FREQ_HZ % SCAN_HZ) != 0 || DIV < 2) begin : g_bad_div
      $error("seg_display_scan: CLK_FREQ_HZ/SCAN_HZ must be an integer >= 2");
    end
  endgenerate

  logic [15:0]           hold_q;
  logic [15:0]           digits;
  logic [CNT_W-1:0]      presc_q;
  logic                  tick;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic                  blank;
  logic [6:0]            seg_d;
  logic [NUM_DIGITS-1:0] an_d;

  // Bypass the hold register while Update is high so a value latched on a
  // tick cycle is decoded by the same edge that advances the index.
  assign digits = Update ? Frequency : hold_q;
  assign tick   = (presc_q == CNT_W'(DIV - 1));
  assign idx_d  = tick ? idx_q + 1'b1 : idx_q;
  assign nibble = digits[{idx_d, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // Digit k is a leading zero when it and every higher nibble are zero.
  assign blank = (idx_d != '0) && ((digits >> {idx_d, 2'b00}) == 16'h0000);
`else
  assign blank = 1'b0;
`endif

  bcd_to_seg7 u_dec (
    .bcd (nibble),
    .seg (glyph)
  );

  always_comb begin
    seg_d = blank ? SEG_BLANK : glyph;
    an_d  = '1;
    an_d[idx_d] = 1'b0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hold_q  <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      An      <= '1;
      Seg     <= SEG_BLANK;
      Dp      <= 1'b1;
    end else begin
      hold_q  <= digits;
      presc_q <= tick ? '0 : presc_q + 1'b1;
      idx_q   <= idx_d;
      An      <= an_d;
      Seg     <= seg_d;
      Dp      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_display_scan.sv
// Self-checking bench for seg_display_scan with CLK_FREQ_HZ=4000, SCAN_HZ=1000.
module tb_seg_display_scan;

  localparam int unsigned DIV = 4;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, GD = 7'b0111111, GB = 7'b1111111;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Update;
  logic [15:0] Frequency;
  logic [6:0]  Seg;
  logic [3:0]  An;
  logic        Dp;

  int checks   = 0;
  int failures = 0;

  seg_display_scan #(.CLK_FREQ_HZ(4000), .SCAN_HZ(1000)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Frequency (Frequency),
    .Update    (Update),
    .Seg       (Seg),
    .An        (An),
    .Dp        (Dp)
  );

  always #5 Clk = ~Clk;

  // Reference model: index = (edges since reset / DIV) mod 4, value shown is
  // whatever the hold register holds after the edge.
  int unsigned m_edges;
  logic [15:0] m_hold;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    case (n)
      4'd0: return G0;  4'd1: return G1;  4'd2: return G2;  4'd3: return G3;
      4'd4: return G4;  4'd5: return G5;  4'd6: return G6;  4'd7: return G7;
      4'd8: return G8;  4'd9: return G9;
      default: return GD;
    endcase
  endfunction

  function automatic logic [6:0] ref_seg(input logic [15:0] v, input int unsigned k);
    logic [15:0] upper;
    upper = v >> (4 * k);
`ifdef LEADING_ZERO_BLANK_EN
    if (k != 0 && upper == 16'h0000) return GB;
`endif
    return ref_glyph(upper[3:0]);
  endfunction

  function automatic logic [3:0] ref_an(input int unsigned k);
    logic [3:0] a;
    a = 4'b1111;
    a[k] = 1'b0;
    return a;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_edges <= 0;
      m_hold  <= '0;
      m_an    <= 4'b1111;
      m_seg   <= GB;
    end else begin
      m_hold  <= Update ? Frequency : m_hold;
      m_edges <= m_edges + 1;
      m_an    <= ref_an(((m_edges + 1) / DIV) % 4);
      m_seg   <= ref_seg(Update ? Frequency : m_hold, ((m_edges + 1) / DIV) % 4);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_model();
    check("an_model",  16'(An),  16'(m_an));
    check("seg_model", 16'(Seg), 16'(m_seg));
    check("dp_off",    16'(Dp),  16'h0001);
  endtask

  typedef struct {
    logic [15:0]     freq;
    logic [3:0][6:0] full;
    logic [3:0][6:0] blank;
  } vec_t;

  vec_t vecs[8];

  int          e;
  int          d;
  logic [3:0]  seen;
  logic        found;
  logic [6:0]  exp_seg;

  task automatic check_digit(input vec_t v, input string name);
    d = -1;
    for (int k = 0; k < 4; k++) if (An[k] == 1'b0) d = k;
    check({name, "_one_hot"}, 16'($countones(~An)), 16'd1);
    if (d >= 0) begin
      seen[d] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
      exp_seg = v.blank[d];
`else
      exp_seg = v.full[d];
`endif
      check(name, 16'(Seg), 16'(exp_seg));
    end
  endtask

  task automatic pulse_update(input logic [15:0] f);
    Frequency = f;
    Update = 1'b1;
    @(negedge Clk);
    Update = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h1234, {G1, G2, G3, G4}, {G1, G2, G3, G4}};
    vecs[1] = '{16'h0050, {G0, G0, G5, G0}, {GB, GB, G5, G0}};
    vecs[2] = '{16'h00A7, {G0, G0, GD, G7}, {GB, GB, GD, G7}};
    vecs[3] = '{16'h0000, {G0, G0, G0, G0}, {GB, GB, GB, G0}};
    vecs[4] = '{16'h9999, {G9, G9, G9, G9}, {G9, G9, G9, G9}};
    vecs[5] = '{16'h0806, {G0, G8, G0, G6}, {GB, G8, G0, G6}};
    vecs[6] = '{16'hF000, {GD, G0, G0, G0}, {GD, G0, G0, G0}};
    vecs[7] = '{16'h0001, {G0, G0, G0, G1}, {GB, GB, GB, G1}};

    Reset = 1'b1; Update = 1'b0; Frequency = '0;
    @(negedge Clk);
    check("rst_an",  16'(An),  16'h000F);
    check("rst_seg", 16'(Seg), 16'h007F);
    check("rst_dp",  16'(Dp),  16'h0001);
    @(negedge Clk);
    Reset = 1'b0;

    // First digit is held for a full DIV period after release.
    @(negedge Clk);
    check("first_an", 16'(An), 16'hE);
    e = 1;
    while (e < 12 && An == 4'hE) begin
      @(negedge Clk);
      e++;
    end
    check("first_change_edge", 16'(e), 16'(DIV));
    check("second_an", 16'(An), 16'hD);

    // Table-driven full scans.
    for (int i = 0; i < 8; i++) begin
      pulse_update(vecs[i].freq);
      seen = '0;
      check_model();
      check_digit(vecs[i], "vec_seg");
      for (int c = 0; c < 16; c++) begin
        @(negedge Clk);
        check_model();
        check_digit(vecs[i], "vec_seg");
      end
      check("vec_all_digits", 16'(seen), 16'h000F);
    end

    // Hold register ignores Frequency without Update.
    pulse_update(16'h1234);
    Frequency = 16'h9999;
    for (int c = 0; c < 16; c++) begin
      @(negedge Clk);
      check_model();
      check_digit(vecs[0], "hold_seg");
    end
    // Update on a tick cycle shows the new value on the very next output.
    found = 1'b0;
    for (int c = 0; c < 2 * DIV && !found; c++) begin
      if (m_edges % DIV == DIV - 1) found = 1'b1;
      else @(negedge Clk);
    end
    check("tick_found", 16'(found), 16'h0001);
    pulse_update(16'h9999);
    check("tick_update_seg", 16'(Seg), 16'(G9));
    check_model();

    // Reset mid-scan aborts immediately, without waiting for a clock.
    repeat (6) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_an",  16'(An),  16'h000F);
    check("mid_rst_seg", 16'(Seg), 16'h007F);
    check_model();
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    check("mid_rel_an", 16'(An), 16'hE);
    check_model();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      Frequency = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      Update    = ($urandom_range(0, 7) == 0);
      Reset     = ($urandom_range(0, 99) == 0);
      @(negedge Clk);
      check_model();
    end
    Reset = 1'b0;
    Update = 1'b0;
    @(negedge Clk);
    check_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
